// File: rtl/riscv_load_store_unit.sv
// Multi-cycle load/store unit: turns datapath memory controls into one
// valid/ack bus transaction, stalls the core, and formats load data.
module riscv_load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] dAddress,
    input  logic [XLEN-1:0] dWriteData,
    output logic [XLEN-1:0] dReadData,
    output logic            stall,
    output logic            done,
    output logic            misaligned,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic            req;
    logic            illegal;
    logic            misalign;
    logic            timeout_hit;
    logic [3:0]      be_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic [XLEN-1:0] load_fmt;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [7:0]      wait_cnt;
    logic            mis_q;
    logic            err_q;

    assign req         = MemRead | MemWrite;
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        unique case (funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b001, 3'b101:         misalign = dAddress[0];
            3'b010:                 misalign = |dAddress[1:0];
            default:                misalign = 1'b0;
        endcase
    end

    // Lane steering is shared by loads and stores; sign only matters on return.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = dWriteData;
        unique case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << dAddress[1:0];
                wdata_nxt = {4{dWriteData[7:0]}};
            end
            2'b01: begin
                be_nxt    = dAddress[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{dWriteData[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = dWriteData;
            end
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
        half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_fmt = {24'd0, byte_lane};
            3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_fmt = {16'd0, half_lane};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    stall     = 1'b1;
                    state_nxt = (illegal | misalign) ? DONE : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done       = (state == DONE);
    assign misaligned = done & mis_q;
    assign bus_err    = done & err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dReadData <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            wait_cnt  <= 8'd0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        mis_q <= ~illegal & misalign;
                        err_q <= illegal;
                        if (!(illegal | misalign)) begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {dAddress[XLEN-1:2], 2'b00};
                            mem_be    <= be_nxt;
                            mem_wdata <= wdata_nxt;
                            f3_q      <= funct3;
                            off_q     <= dAddress[1:0];
                            wait_cnt  <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            dReadData <= load_fmt;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        if (!mem_we)
                            dReadData <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/riscv_load_store_unit.md
# riscv_load_store_unit

Multi-cycle load/store unit sitting directly downstream of the single-cycle datapath's memory port: it consumes the datapath's data address, store data and memory-control signals, runs a valid/ack transaction on the data-memory bus, and returns aligned, sign- or zero-extended load data on `dReadData`. It stalls the processor while a transaction is outstanding. It also reports misaligned accesses, illegal size encodings and bus timeouts.

## Interface
- `XLEN`, 32: data and address width; only 32 is supported.
- `TIMEOUT_CYCLES`, 255: maximum cycles in REQ without `mem_ack` before a bus error; range 1..255.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request for the current instruction.
- `MemWrite`  in  1  store request for the current instruction.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `dAddress`  in  XLEN  byte address (ALU result).
- `dWriteData`  in  XLEN  store data (rs2).
- `dReadData`  out  XLEN  formatted load data, registered.
- `stall`  out  1  hold PC/instruction this cycle.
- `done`  out  1  one-cycle pulse when an access completes.
- `misaligned`  out  1  valid with `done`; the access was misaligned.
- `bus_err`  out  1  valid with `done`; the access timed out or used an illegal `funct3`.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  XLEN  word address (`dAddress` with bits [1:0] forced to 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_ack`  in  1  memory completion.
- `mem_rdata`  in  XLEN  read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - Idle when neither `MemRead` nor `MemWrite` is set.
  - A request is `MemRead | MemWrite`. If both are set, the access is a write.
  - On a request, `stall` = 1 combinationally, then:
    - Illegal `funct3` (011, 110, 111): go to DONE with `bus_err` = 1. No bus cycle.
    - H/HU with `dAddress[0]` = 1, or W with `dAddress[1:0]` ≠ 0: go to DONE with `misaligned` = 1. No bus cycle.
    - Otherwise: register `mem_addr`, `mem_be`, `mem_wdata`, `mem_we`, `funct3` and `dAddress[1:0]`; go to REQ.
- **Byte enables and store data**
  - B: `mem_be` = 1 << `addr[1:0]`; `mem_wdata` = byte replicated ×4.
  - H: `mem_be` = 0011 if `addr[1]` = 0, else 1100; `mem_wdata` = halfword replicated ×2.
  - W: `mem_be` = 1111.
  - For loads, `mem_be` is computed the same way.
- **REQ**
  - `mem_req` = 1 and `stall` = 1.
  - A 8-bit wait counter increments each cycle spent in REQ.
  - On `mem_ack` = 1 at an edge: drop `mem_req` and go to DONE. For a load, also update `dReadData` at that edge:
    - B: sign-extend the selected byte lane.
    - BU: zero-extend the selected byte lane.
    - H: sign-extend the selected halfword.
    - HU: zero-extend the selected halfword.
    - W: whole word.
  - If the counter reaches `TIMEOUT_CYCLES` with no ack: drop `mem_req`, go to DONE with `bus_err` = 1, and load `dReadData` = 0 if the access was a load.
- **DONE**
  - `stall` = 0 and `done` = 1. `misaligned` and `bus_err` reflect the access; both are 0 in every other state.
  - Next state is always IDLE.
  - The processor advances at the edge ending DONE; the next request is seen in IDLE on the following cycle.
- **Hold and ignore rules**
  - `dReadData` holds its value through stores and faults except load timeouts; it changes only on load completion.
  - `mem_ack` outside REQ is ignored.
  - `MemRead`, `MemWrite`, `funct3`, `dAddress` and `dWriteData` are sampled only in IDLE; changes during REQ are ignored.

## Timing
- **Reset** (asserted asynchronously):
  - State goes to IDLE.
  - `dReadData`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` = 0.
  - `done`, `misaligned`, `bus_err` = 0 and the wait counter = 0.
  - `stall` = 0 unless a request is present.
- Reset mid-REQ drops `mem_req` immediately. The aborted access produces no `done`.
- Best-case latency with ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE). `stall` is high for 2 of them.
- Each additional ack wait cycle adds 1 cycle.
- Faulted accesses (misaligned, illegal `funct3`) take 2 cycles (IDLE, DONE).
- Timeout: `bus_err` appears `TIMEOUT_CYCLES` + 1 cycles after leaving IDLE.
- `mem_req` rises at the edge leaving IDLE and falls at the ack or timeout edge. There is never more than one outstanding request.

## Test plan
- LW at 0x1000_0008, ack in first REQ cycle with `mem_rdata` = 0xDEADBEEF → `mem_be` = 1111; `dReadData` = 0xDEADBEEF; `done` in cycle 3; `stall` high in cycles 1–2.
- LB at 0x…03 and LBU at 0x…03 with `mem_rdata` = 0x80FF_0000 → LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x…02 with `dWriteData` = 0x0000_1234, ack after 4 wait cycles → `mem_be` = 1100; `mem_wdata` = 0x1234_1234; `mem_we` = 1; `stall` high for 6 cycles; `dReadData` unchanged.
- LW at 0x…06 → no `mem_req`; `done` = 1 and `misaligned` = 1 in cycle 2. `funct3` = 011 → `bus_err` = 1 in cycle 2 with no bus cycle.
- With `TIMEOUT_CYCLES` = 4, a load with `mem_ack` held at 0 → `mem_req` drops after 4 REQ cycles; `bus_err` = 1 with `done`; `dReadData` = 0.
- `rst` driven low during the 2nd REQ cycle → `mem_req` = 0 immediately, no `done`. After release, a fresh LW completes normally.
